// File: rtl/tqvp_stevej_pat_scheduler.sv
// rtl/tqvp_stevej_pat_scheduler.sv - watchdog PAT sequencer gated on per-task heartbeats
// Optional early-warning output enabled by defining PAT_SCHED_EARLY_WARN_EN.
module tqvp_stevej_pat_scheduler #(
   parameter int         NUM_TASKS = 4,
   parameter int         CNT_W     = 32,
   parameter logic [5:0] PAT_ADDR  = 6'h3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [NUM_TASKS-1:0] task_mask,
   input  logic [NUM_TASKS-1:0] task_beat,
   input  logic [CNT_W-1:0]     min_interval,
   input  logic [CNT_W-1:0]     max_interval,
   input  logic [CNT_W-1:0]     warn_margin,
   input  logic                 clear_missed,
   output logic                 pat_req,
   output logic [5:0]           pat_addr,
   input  logic                 pat_ack,
   output logic                 missed,
   output logic [NUM_TASKS-1:0] missed_tasks,
   output logic                 early_warn,
   output logic [7:0]           pat_count,
   output logic [2:0]           state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_COLLECT   = 3'd1,
      S_WAIT_OPEN = 3'd2,
      S_PAT       = 3'd3,
      S_FAULT     = 3'd4
   } state_t;

   state_t               cur;
   logic [CNT_W-1:0]     counter;
   logic [CNT_W-1:0]     counter_inc;
   logic [NUM_TASKS-1:0] seen;
   logic [NUM_TASKS-1:0] next_seen;
   logic [NUM_TASKS-1:0] beat_m;
   logic                 all_in;
   logic                 open_ok;
   logic                 deadline;
   logic                 warn_hit;

   assign beat_m      = task_beat & task_mask;
   assign all_in      = ((seen | task_beat) & task_mask) == task_mask;
   assign open_ok     = counter >= min_interval;
   assign deadline    = counter >= max_interval;
   assign counter_inc = (&counter) ? counter : counter + 1'b1;

`ifdef PAT_SCHED_EARLY_WARN_EN
   // One extra bit keeps counter + margin from wrapping past the deadline.
   logic [CNT_W:0] warn_sum;
   assign warn_sum = {1'b0, counter} + {1'b0, warn_margin};
   assign warn_hit = warn_sum >= {1'b0, max_interval};
`else
   logic unused_warn_margin;
   assign unused_warn_margin = ^warn_margin;
   assign warn_hit = 1'b0;
`endif

   assign pat_req  = (cur == S_PAT);
   assign pat_addr = pat_req ? PAT_ADDR : 6'd0;
   assign state    = cur;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur          <= S_IDLE;
         counter      <= '0;
         seen         <= '0;
         next_seen    <= '0;
         missed       <= 1'b0;
         missed_tasks <= '0;
         early_warn   <= 1'b0;
         pat_count    <= 8'd0;
      end else if (!enable) begin
         cur          <= S_IDLE;
         counter      <= '0;
         seen         <= '0;
         next_seen    <= '0;
         missed       <= 1'b0;
         missed_tasks <= '0;
         early_warn   <= 1'b0;
      end else begin
         early_warn <= 1'b0;
         case (cur)
            S_IDLE: begin
               cur     <= S_COLLECT;
               counter <= '0;
            end
            S_COLLECT: begin
               seen <= seen | beat_m;
               // A round completing on the deadline cycle still counts as on time.
               if (all_in && open_ok) begin
                  cur <= S_PAT;
               end else if (all_in) begin
                  cur     <= S_WAIT_OPEN;
                  counter <= counter_inc;
               end else if (deadline) begin
                  cur          <= S_FAULT;
                  missed       <= 1'b1;
                  missed_tasks <= task_mask & ~(seen | task_beat);
               end else begin
                  counter    <= counter_inc;
                  early_warn <= warn_hit;
               end
            end
            S_WAIT_OPEN: begin
               counter <= counter_inc;
               if (open_ok) cur <= S_PAT;
            end
            S_PAT: begin
               next_seen <= next_seen | beat_m;
               if (pat_ack) begin
                  cur       <= S_COLLECT;
                  counter   <= '0;
                  seen      <= next_seen | beat_m;
                  next_seen <= '0;
                  pat_count <= pat_count + 8'd1;
               end
            end
            S_FAULT: begin
               if (clear_missed) begin
                  cur          <= S_COLLECT;
                  counter      <= '0;
                  seen         <= '0;
                  next_seen    <= '0;
                  missed       <= 1'b0;
                  missed_tasks <= '0;
               end
            end
            default: cur <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tqvp_stevej_pat_scheduler.sv
// tb/tb_tqvp_stevej_pat_scheduler.sv - self-checking bench for tqvp_stevej_pat_scheduler
module tb_tqvp_stevej_pat_scheduler;

   localparam int PH_IDLE = 0, PH_COLLECT = 1, PH_WAIT = 2, PH_PAT = 3, PH_FAULT = 4;
   localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [3:0]  task_mask;
   logic [3:0]  task_beat;
   logic [31:0] min_interval;
   logic [31:0] max_interval;
   logic [31:0] warn_margin;
   logic        clear_missed;
   logic        pat_req;
   logic [5:0]  pat_addr;
   logic        pat_ack;
   logic        missed;
   logic [3:0]  missed_tasks;
   logic        early_warn;
   logic [7:0]  pat_count;
   logic [2:0]  state;

   tqvp_stevej_pat_scheduler dut (
      .clk(clk), .rst(rst), .enable(enable), .task_mask(task_mask), .task_beat(task_beat),
      .min_interval(min_interval), .max_interval(max_interval), .warn_margin(warn_margin),
      .clear_missed(clear_missed), .pat_req(pat_req), .pat_addr(pat_addr), .pat_ack(pat_ack),
      .missed(missed), .missed_tasks(missed_tasks), .early_warn(early_warn),
      .pat_count(pat_count), .state(state)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: round bookkeeping expressed directly from the rules.
   int         m_ph;
   longint     m_cnt;
   logic [3:0] m_seen, m_ns, m_mt;
   bit         m_missed, m_ew;
   int         m_pc;

   typedef struct {
      logic [3:0] mask;
      int         mn, mx;
      int         b0, b1, b2, b3;
      int         ack_dly;
      int         run;
      logic [2:0] exp_state;
      logic [3:0] exp_mt;
      int         exp_pats;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset(input bit clr_count);
      m_ph = PH_IDLE; m_cnt = 0; m_seen = 0; m_ns = 0;
      m_mt = 0; m_missed = 0; m_ew = 0;
      if (clr_count) m_pc = 0;
   endtask

   task automatic model_step();
      logic [3:0] bm;
      bit         allin, ew_next;
      longint     mn, mx, mg;
      bm    = task_beat & task_mask;
      allin = (((m_seen | task_beat) & task_mask) == task_mask);
      mn = {32'b0, min_interval};
      mx = {32'b0, max_interval};
      mg = {32'b0, warn_margin};
      ew_next = 0;
      if (!enable) begin
         model_reset(0);
         return;
      end
      case (m_ph)
         PH_IDLE: begin m_ph = PH_COLLECT; m_cnt = 0; end
         PH_COLLECT: begin
            m_seen = m_seen | bm;
            if (allin && m_cnt >= mn) m_ph = PH_PAT;
            else if (allin) begin m_ph = PH_WAIT; m_cnt = (m_cnt + 1 > SAT) ? SAT : m_cnt + 1; end
            else if (m_cnt >= mx) begin m_ph = PH_FAULT; m_missed = 1; m_mt = task_mask & ~m_seen; end
            else begin
               ew_next = (m_cnt + mg >= mx);
               m_cnt = (m_cnt + 1 > SAT) ? SAT : m_cnt + 1;
            end
         end
         PH_WAIT: begin
            if (m_cnt >= mn) m_ph = PH_PAT;
            m_cnt = (m_cnt + 1 > SAT) ? SAT : m_cnt + 1;
         end
         PH_PAT: begin
            m_ns = m_ns | bm;
            if (pat_ack) begin
               m_ph = PH_COLLECT; m_cnt = 0; m_seen = m_ns; m_ns = 0;
               m_pc = (m_pc + 1) % 256;
            end
         end
         PH_FAULT: begin
            if (clear_missed) begin
               m_ph = PH_COLLECT; m_cnt = 0; m_seen = 0; m_ns = 0; m_missed = 0; m_mt = 0;
            end
         end
         default: m_ph = PH_IDLE;
      endcase
`ifdef PAT_SCHED_EARLY_WARN_EN
      m_ew = ew_next;
`else
      m_ew = 0;
`endif
   endtask

   task automatic check_all();
      chk("state", {29'b0, state}, m_ph);
      chk("pat_req", {31'b0, pat_req}, (m_ph == PH_PAT) ? 1 : 0);
      chk("pat_addr", {26'b0, pat_addr}, (m_ph == PH_PAT) ? 3 : 0);
      chk("missed", {31'b0, missed}, {31'b0, m_missed});
      chk("missed_tasks", {28'b0, missed_tasks}, {28'b0, m_mt});
      chk("pat_count", {24'b0, pat_count}, m_pc);
      chk("early_warn", {31'b0, early_warn}, {31'b0, m_ew});
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) model_step();
      #1;
      check_all();
   endtask

   task automatic run_vec(input vec_t v);
      int pw, prev, pc0;
      task_mask = v.mask; min_interval = v.mn; max_interval = v.mx; warn_margin = 0;
      clear_missed = 0; pat_ack = 0; task_beat = 0;
      enable = 0; tick();
      enable = 1;
      pc0 = m_pc;
      pw = 0;
      for (int c = 0; c < v.run; c++) begin
         task_beat = {v.b3 == c, v.b2 == c, v.b1 == c, v.b0 == c};
         pat_ack = (m_ph == PH_PAT && pw == v.ack_dly);
         prev = m_ph;
         tick();
         pw = (prev == PH_PAT && m_ph == PH_PAT) ? pw + 1 : 0;
      end
      task_beat = 0; pat_ack = 0;
      chk("vec_state", {29'b0, state}, {29'b0, v.exp_state});
      chk("vec_missed_tasks", {28'b0, missed_tasks}, {28'b0, v.exp_mt});
      chk("vec_pat_count", {24'b0, pat_count}, (pc0 + v.exp_pats) % 256);
   endtask

   initial begin
      int pc_save;
      //           mask     mn  mx   b0  b1  b2  b3 ack run st    mt       pats
      vecs[0] = '{4'b0011, 10, 100,  4,  6, -1, -1, 2, 20, 3'd1, 4'b0000, 1};
      vecs[1] = '{4'b0111,  5,  50,  3, -1, 10, -1, 0, 60, 3'd4, 4'b0010, 0};
      vecs[2] = '{4'b1111,  5,  20, 21, 21, 21, 21, 0, 25, 3'd1, 4'b0000, 1};
      vecs[3] = '{4'b1111, 30,  20, 21, 21, 21, 21, 5, 33, 3'd3, 4'b0000, 0};
      vecs[4] = '{4'b0000,  3,  10, -1, -1, -1, -1, 1,  8, 3'd2, 4'b0000, 1};
      vecs[5] = '{4'b0001,  2,   8, -1,  2, -1, -1, 0, 12, 3'd4, 4'b0001, 0};
      vecs[6] = '{4'b0001,  0,   0, -1, -1, -1, -1, 0,  3, 3'd4, 4'b0001, 0};

      rst = 1; enable = 0; task_mask = 0; task_beat = 0; min_interval = 0;
      max_interval = 0; warn_margin = 0; clear_missed = 0; pat_ack = 0;
      model_reset(1);
      #2;
      check_all();
      #12 rst = 0;
      tick();

      foreach (vecs[i]) run_vec(vecs[i]);

      // Beat landing during PAT carries into the next round.
      task_mask = 4'b0011; min_interval = 2; max_interval = 50;
      enable = 0; tick(); enable = 1; tick();
      task_beat = 4'b0011; tick();
      task_beat = 4'b0000; tick(); tick();
      chk("carry_in_pat", {29'b0, state}, 3);
      task_beat = 4'b0010; tick();
      task_beat = 4'b0000; pat_ack = 1; tick();
      chk("carry_after_ack", {29'b0, state}, 1);
      pat_ack = 0; task_beat = 4'b0001; tick();
      chk("carry_round_done", {29'b0, state}, 2);
      task_beat = 0;

      // Enable dropped while requesting; a late ack is ignored.
      tick(); tick();
      chk("drop_pat_req", {31'b0, pat_req}, 1);
      pc_save = m_pc;
      enable = 0; tick();
      chk("drop_state", {29'b0, state}, 0);
      chk("drop_req_low", {31'b0, pat_req}, 0);
      pat_ack = 1; tick();
      chk("late_ack", {24'b0, pat_count}, pc_save);
      pat_ack = 0;

      // Fault, frozen, then cleared.
      task_mask = 4'b0001; min_interval = 0; max_interval = 3;
      enable = 1;
      for (int i = 0; i < 8; i++) tick();
      chk("fault_missed", {31'b0, missed}, 1);
      chk("fault_state", {29'b0, state}, 4);
      clear_missed = 1; tick(); clear_missed = 0;
      chk("clear_state", {29'b0, state}, 1);
      chk("clear_missed", {31'b0, missed}, 0);

      // Early-warning window ahead of the deadline.
      task_mask = 4'b0001; min_interval = 0; max_interval = 100; warn_margin = 20;
      enable = 0; tick(); enable = 1; tick();
      for (int c = 1; c <= 103; c++) begin
         tick();
`ifdef PAT_SCHED_EARLY_WARN_EN
         chk("ew_window", {31'b0, early_warn}, (c - 1 >= 80 && c - 1 <= 99) ? 1 : 0);
`else
         chk("ew_window", {31'b0, early_warn}, 0);
`endif
      end

      // Async reset mid-COLLECT.
      clear_missed = 1; tick(); clear_missed = 0;
      tick(); tick();
      #2 rst = 1;
      #1;
      model_reset(1);
      chk("async_state", {29'b0, state}, 0);
      chk("async_pat_count", {24'b0, pat_count}, 0);
      check_all();
      #1 rst = 0;

      // Randomized traffic against the model.
      min_interval = $urandom_range(0, 12); max_interval = $urandom_range(0, 30);
      warn_margin = $urandom_range(0, 10); task_mask = $urandom_range(0, 15);
      enable = 1;
      for (int i = 0; i < 4000; i++) begin
         enable       = ($urandom_range(0, 63) != 0);
         task_beat    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
         pat_ack      = ($urandom_range(0, 2) == 0);
         clear_missed = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 99) == 0) task_mask = $urandom_range(0, 15);
         if ($urandom_range(0, 199) == 0) begin
            min_interval = $urandom_range(0, 12);
            max_interval = $urandom_range(0, 30);
            warn_margin  = $urandom_range(0, 10);
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
